apb_master_fsm: RTL and testbench
=================================

APB_MASTER_FSM -- requirements
Module: apb_master_fsm

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, which sets the paddr and cmd_addr width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, which sets the data bus width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, which sets the maximum number of ACCESS wait cycles (used only with APB_MASTER_TIMEOUT_EN).
REQ-004 The block SHALL have port pclk, input, 1 bit: the single clock; all flops are rising-edge triggered.
REQ-005 The block SHALL have port preset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: the requester has a transfer pending.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-008 The block SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port cmd_addr, input, ADDR_WIDTH bits: the transfer address.
REQ-010 The block SHALL have port cmd_wdata, input, DATA_WIDTH bits: the write data.
REQ-011 The block SHALL have APB ports psel, penable and pwrite (outputs, 1 bit each), paddr (output, ADDR_WIDTH), and pwdata (output, DATA_WIDTH).
REQ-012 The block SHALL have APB ports pready (input, 1 bit), prdata (input, DATA_WIDTH) and pslverr (input, 1 bit).
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-014 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data, valid with rsp_valid.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: error flag, valid with rsp_valid.

Function
REQ-016 The block SHALL implement the three states IDLE, SETUP and ACCESS, held in registered state.
REQ-017 In IDLE the block SHALL drive cmd_ready=1, psel=0 and penable=0; in every other state it SHALL drive cmd_ready=0.
REQ-018 On the cycle where cmd_valid and cmd_ready are both 1, the block SHALL capture cmd_write, cmd_addr and cmd_wdata and go to SETUP.
REQ-019 The block SHALL ignore cmd_valid while cmd_ready=0, and the requester SHALL hold the command until it is accepted.
REQ-020 SETUP SHALL last exactly one cycle, with psel=1 and penable=0, and SHALL always go to ACCESS next.
REQ-021 In ACCESS the block SHALL drive psel=1 and penable=1, and SHALL stay in ACCESS while pready=0.
REQ-022 When pready=1 is sampled in ACCESS, the block SHALL go to IDLE.
REQ-023 In the cycle after pready=1 is sampled in ACCESS, the block SHALL pulse rsp_valid=1 for one cycle with these values:
  - rsp_err = the sampled pslverr;
  - rsp_rdata = the sampled prdata for a read, and 0 for a write.
REQ-024 The block SHALL register paddr, pwrite and pwdata, hold them stable from SETUP through the end of ACCESS, and keep their last values in IDLE.
REQ-025 The block SHALL ignore pslverr and prdata in every cycle except the ACCESS cycle with pready=1.
REQ-026 Latency: with a command accepted at cycle 0 and pready=1 at cycle 2, the block SHALL give rsp_valid=1 and cmd_ready=1 at cycle 3, so the minimum is 3 cycles per transfer.
REQ-027 The block SHALL accept a new command in the same cycle that rsp_valid is high.
REQ-028 rsp_rdata and rsp_err SHALL hold their values between responses.

Reset
REQ-029 When preset=1, the block SHALL immediately (asynchronously) force:
  - state = IDLE;
  - psel=0, penable=0, pwrite=0;
  - paddr=0, pwdata=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - cmd_ready=1.
REQ-030 A reset during SETUP or ACCESS SHALL abort the transfer, and the block SHALL NOT produce a response for the aborted transfer.
REQ-031 After preset deasserts, the first rising edge SHALL be able to accept a command.

Configuration
REQ-032 With macro APB_MASTER_TIMEOUT_EN defined, the block SHALL count the ACCESS cycles that have pready=0.
  - If the count reaches TIMEOUT_CYCLES, the block SHALL go to IDLE and pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
  - The counter SHALL clear on entry to SETUP and on reset.
  - pready=1 in the same cycle as the count limit SHALL count as a normal completion.
REQ-033 Without APB_MASTER_TIMEOUT_EN, the block SHALL contain no counter and SHALL wait in ACCESS indefinitely.

Verification
REQ-034 Write, no wait: cmd_write=1, cmd_addr=0x04, cmd_wdata=0xA5, pready tied to 1 -> SETUP at cycle 1 with paddr=0x04, pwdata=0xA5, pwrite=1; ACCESS at cycle 2; rsp_valid=1, rsp_err=0 at cycle 3.
REQ-035 Read with 2 wait states: cmd_addr=0x08, pready=0,0,1, prdata=0x3C on the third ACCESS cycle -> rsp_rdata=0x3C, rsp_err=0; paddr stays 0x08 for all three ACCESS cycles.
REQ-036 Slave error: read with pready=1 and pslverr=1 -> rsp_valid=1, rsp_err=1.
REQ-037 Back-to-back: cmd_valid held high for two commands -> second SETUP starts in the cycle after the first rsp_valid; cmd_ready=0 throughout both transfers except in IDLE.
REQ-038 Reset mid-ACCESS: assert preset while pready=0 -> psel=0 and penable=0 in the same cycle, with no rsp_valid afterwards.
REQ-039 Timeout (macro defined, TIMEOUT_CYCLES=16): pready held at 0 -> rsp_valid=1, rsp_err=1 after 16 ACCESS cycles, then IDLE; without the macro, psel and penable stay 1 for 100 cycles.

Source files
------------

// File: rtl/apb_master_fsm.sv
// APB master: turns one requester command into one APB SETUP/ACCESS transfer and a one-cycle response.
// Optional ACCESS wait timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_fsm #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  // Command handshake: a command transfers on a cycle where cmd_valid && cmd_ready.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_timeout;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;
  assign w_done   = (r_state == ST_ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  // Counts ACCESS cycles without pready; a pready on the limit cycle wins.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !pready) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == ST_ACCESS) && !pready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (cmd_valid) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (pready || w_timeout) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
    end
  end

  // Response fields are only updated on completion so they hold between pulses.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_done || w_timeout;
      if (w_done) begin
        r_rsp_rdata <= r_pwrite ? '0 : prdata;
        r_rsp_err   <= pslverr;
      end else if (w_timeout) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign psel        = (r_state != ST_IDLE);
  assign penable     = (r_state == ST_ACCESS);
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Self-checking bench for apb_master_fsm: directed scenarios plus randomized transfers
// against a transaction-level response model.
module tb_apb_master_fsm;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  // clock / reset
  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [1:0]    dbg_state;

  apb_master_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: expected responses as {err, rdata}
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_exp;
  logic [DW:0] last_rsp = '0;

  always @(negedge pclk) begin
    if (preset) begin
      last_rsp = '0;
    end else if (rsp_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 err=%0b rdata=%02h, required no response", rsp_err, rsp_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== mon_exp) begin
          n_errors++;
          $display("FAIL rsp_data: got err=%0b rdata=%02h, required err=%0b rdata=%02h",
                   rsp_err, rsp_rdata, mon_exp[DW], mon_exp[DW-1:0]);
        end
      end
      last_rsp = {rsp_err, rsp_rdata};
    end else begin
      n_checks++;
      if ({rsp_err, rsp_rdata} !== last_rsp) begin
        n_errors++;
        $display("FAIL rsp_hold: got err=%0b rdata=%02h, required err=%0b rdata=%02h",
                 rsp_err, rsp_rdata, last_rsp[DW], last_rsp[DW-1:0]);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    pready = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // One complete transfer; starts and ends 1 time unit after a rising edge.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input logic err, input logic [DW-1:0] rdata,
                          input logic keep_valid);
    logic [AW+DW+3:0] exp_bus;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_ready: got cmd_ready=%0b, required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = DW'($urandom);
    exp_q.push_back({err, wr ? {DW{1'b0}} : rdata});
    step();
    exp_bus = {1'b1, 1'b0, 1'b0, wr, addr, wdata};
    n_checks++;
    if ({psel, penable, cmd_ready, pwrite, paddr, pwdata} !== exp_bus) begin
      n_errors++;
      $display("FAIL setup_bus: got sel=%0b en=%0b rdy=%0b wr=%0b addr=%02h wdata=%02h, required 1 0 0 %0b %02h %02h",
               psel, penable, cmd_ready, pwrite, paddr, pwdata, wr, addr, wdata);
    end
    cmd_valid = keep_valid;
    cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = DW'($urandom);
    step();
    exp_bus = {1'b1, 1'b1, 1'b0, wr, addr, wdata};
    for (int i = 0; i <= waits; i++) begin
      n_checks++;
      if ({psel, penable, cmd_ready, pwrite, paddr, pwdata, rsp_valid} !== {exp_bus, 1'b0}) begin
        n_errors++;
        $display("FAIL access_bus[%0d]: got sel=%0b en=%0b rdy=%0b wr=%0b addr=%02h wdata=%02h rv=%0b, required 1 1 0 %0b %02h %02h 0",
                 i, psel, penable, cmd_ready, pwrite, paddr, pwdata, rsp_valid, wr, addr, wdata);
      end
      if (i == waits) begin
        pready = 1'b1; pslverr = err; prdata = rdata;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom); prdata = DW'($urandom);
      end
      step();
    end
    cmd_valid = 1'b0;
    pready = 1'b0; pslverr = 1'($urandom); prdata = DW'($urandom);
    n_checks++;
    if ({rsp_valid, cmd_ready, psel, penable, paddr} !== {1'b1, 1'b1, 1'b0, 1'b0, addr}) begin
      n_errors++;
      $display("FAIL completion: got rv=%0b rdy=%0b sel=%0b en=%0b addr=%02h, required 1 1 0 0 %02h",
               rsp_valid, cmd_ready, psel, penable, paddr, addr);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, cmd_ready} !==
        {3'b000, {AW{1'b0}}, {DW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL %s: got sel=%0b en=%0b wr=%0b addr=%02h wdata=%02h rv=%0b rdata=%02h err=%0b rdy=%0b, required all 0 with rdy=1",
               name, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, cmd_ready);
    end
  endtask

  // scenarios
  task automatic test_reset();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'hAA; pready = 1'b1;
    step(); step();
    check_reset_outputs("reset_state");
    cmd_valid = 1'b0; pready = 1'b0;
    preset = 1'b0;
  endtask

  task automatic test_write_nowait();
    run_xfer(1'b1, 8'h04, 8'hA5, 0, 1'b0, 8'hEE, 1'b0);
    idle(2);
  endtask

  task automatic test_read_wait();
    run_xfer(1'b0, 8'h08, 8'h00, 2, 1'b0, 8'h3C, 1'b0);
    idle(1);
  endtask

  task automatic test_slverr();
    run_xfer(1'b0, 8'h0C, 8'h11, 0, 1'b1, 8'h77, 1'b0);
    idle(1);
    run_xfer(1'b1, 8'h0D, 8'h22, 1, 1'b1, 8'h99, 1'b0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b1, 8'h10, 8'h11, 0, 1'b0, 8'h00, 1'b1);
    run_xfer(1'b0, 8'h20, 8'h00, 1, 1'b0, 8'h5A, 1'b1);
    run_xfer(1'b0, 8'h30, 8'h00, 0, 1'b0, 8'hC3, 1'b0);
    idle(2);
  endtask

  task automatic test_reset_mid_access();
    int hits;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h44; cmd_wdata = 8'h66;
    step();
    cmd_valid = 1'b0; pready = 1'b0;
    step(); step(); step();
    #2 preset = 1'b1;
    #1 check_reset_outputs("reset_mid_access");
    @(posedge pclk); #1;
    preset = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid === 1'b1) hits++;
      step();
    end
    n_checks++;
    if (hits != 0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_no_rsp: got %0d rsp_valid cycles, cmd_ready=%0b, required 0 and 1", hits, cmd_ready);
    end
  endtask

  task automatic test_timeout();
    int n;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h70; cmd_wdata = 8'h00;
    step();
    cmd_valid = 1'b0; pready = 1'b0;
    step();
`ifdef APB_MASTER_TIMEOUT_EN
    exp_q.push_back({1'b1, {DW{1'b0}}});
    n = 0;
    while (psel === 1'b1 && penable === 1'b1 && n < 100) begin
      pslverr = 1'($urandom); prdata = DW'($urandom);
      n++;
      step();
    end
    n_checks++;
    if (n != TO || rsp_valid !== 1'b1 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout: got %0d ACCESS cycles rv=%0b rdy=%0b, required %0d 1 1", n, rsp_valid, cmd_ready, TO);
    end
    idle(1);
    run_xfer(1'b0, 8'h71, 8'h00, TO - 1, 1'b0, 8'h81, 1'b0);
    idle(1);
`else
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (psel === 1'b1 && penable === 1'b1 && rsp_valid === 1'b0) n++;
      pslverr = 1'($urandom); prdata = DW'($urandom);
      step();
    end
    n_checks++;
    if (n != 100) begin
      n_errors++;
      $display("FAIL no_timeout: got %0d of 100 cycles in ACCESS, required 100", n);
    end
    #2 preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    idle(1);
`endif
  endtask

  task automatic test_random();
    logic          wr, err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom); err = ($urandom_range(0, 3) == 0);
      addr = AW'($urandom); wdata = DW'($urandom); rdata = DW'($urandom);
      run_xfer(wr, addr, wdata, $urandom_range(0, 5), err, rdata, 1'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_nowait();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_rsp: got %0d outstanding responses, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
